// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;
  localparam int DATA_W = 16;
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;
endpackage

// File: rtl/dmem_ram.sv
// Data-memory storage: one address port, synchronous write, asynchronous read.
module dmem_ram
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];
endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder with optional read wait states.
// Define DMEM_WAIT_EN to insert WAIT_CYCLES wait states before each read response.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        read_ready,
  output logic [15:0] rdata,
  output logic        write_done,
  output logic        busy
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              read_ready_q, read_ready_d;
  logic              write_done_q, write_done_d;

  logic              idle;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;

`ifdef DMEM_WAIT_EN
  localparam logic [WAIT_W-1:0] WAIT_COUNT = WAIT_W'(WAIT_CYCLES);
  logic [WAIT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_wait_cfg;
  assign unused_wait_cfg = |WAIT_CYCLES;
`endif

  if (ADDR_W < 16) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[15:ADDR_W];
  end

  assign idle = (state_q == ST_IDLE);

  // Writes only happen in IDLE, so the single RAM port is shared with the
  // latched read address whenever a read is in flight.
  assign ram_we   = idle & write;
  assign ram_addr = idle ? addr[ADDR_W-1:0] : addr_q;

  dmem_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(wdata),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rdata_d      = rdata_q;
    read_ready_d = 1'b0;
    write_done_d = 1'b0;
`ifdef DMEM_WAIT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        write_done_d = write;
        if (read) begin
          addr_d = addr[ADDR_W-1:0];
`ifdef DMEM_WAIT_EN
          cnt_d   = WAIT_COUNT;
          state_d = (WAIT_COUNT != '0) ? ST_WAIT : ST_RESP;
`else
          state_d = ST_RESP;
`endif
        end
      end
`ifdef DMEM_WAIT_EN
      ST_WAIT: begin
        cnt_d = cnt_q - WAIT_W'(1);
        if (cnt_q <= WAIT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
`endif
      ST_RESP: begin
        read_ready_d = 1'b1;
        rdata_d      = ram_rdata;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      rdata_q      <= '0;
      read_ready_q <= 1'b0;
      write_done_q <= 1'b0;
`ifdef DMEM_WAIT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rdata_q      <= rdata_d;
      read_ready_q <= read_ready_d;
      write_done_q <= write_done_d;
`ifdef DMEM_WAIT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign read_ready = read_ready_q;
  assign rdata      = rdata_q;
  assign write_done = write_done_q;
  assign busy       = ~idle;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed scenarios plus random traffic
// against a cycle-count/array reference model.
`timescale 1ns/1ps
module tb_dmem_responder;
  localparam int ADDR_W      = 8;
  localparam int WAIT_CYCLES = 2;
`ifdef DMEM_WAIT_EN
  localparam int LAT = WAIT_CYCLES;
`else
  localparam int LAT = 0;
`endif
  localparam int DEPTH = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic        read_ready, write_done, busy;
  logic [15:0] rdata;

  dmem_responder #(
    .ADDR_W     (ADDR_W),
    .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .read      (read),
    .write     (write),
    .addr      (addr),
    .wdata     (wdata),
    .read_ready(read_ready),
    .rdata     (rdata),
    .write_done(write_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    int          due;
  } rd_exp_t;

  logic [15:0] ref_mem [DEPTH];
  rd_exp_t     rd_q[$];
  int          wd_q[$];
  int          idle_from = 0;
  logic [15:0] held = '0;
  bit          mon_en = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, got, exp);
    end
  endtask

  // One bus cycle: the request is sampled at edge e = cyc+1. The model is
  // idle at that edge iff e >= idle_from.
  task automatic issue(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
    int e;
    int idx;
    e   = cyc + 1;
    idx = int'(a) % DEPTH;
    chk("busy", {15'd0, busy}, {15'd0, (e < idle_from)});
    read  = rd;
    write = wr;
    addr  = a;
    wdata = d;
    if (e >= idle_from && (rd || wr)) begin
      if (wr) begin
        ref_mem[idx] = d;
        wd_q.push_back(e);
        idle_from = e + 1;
      end
      if (rd) begin
        rd_q.push_back('{data: ref_mem[idx], due: e + 1 + LAT});
        idle_from = e + 2 + LAT;
      end
    end
    @(posedge clk);
    #1;
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) issue(1'b0, 1'b0, 16'($urandom), 16'($urandom));
  endtask

  task automatic do_reset();
    rd_q.delete();
    wd_q.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    held      = '0;
    idle_from = cyc + 1;
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_read_ready", {15'd0, read_ready}, 16'd0);
    chk("rst_write_done", {15'd0, write_done}, 16'd0);
    chk("rst_rdata", rdata, 16'h0000);
  endtask

  always @(negedge clk) begin
    rd_exp_t x;
    int      wdue;
    if (mon_en && !rst) begin
      while (rd_q.size() > 0 && rd_q[0].due < cyc) begin
        x = rd_q.pop_front();
        chk_int("rd_missing", cyc, x.due);
      end
      while (wd_q.size() > 0 && wd_q[0] < cyc) begin
        wdue = wd_q.pop_front();
        chk_int("wd_missing", cyc, wdue);
      end
      if (read_ready) begin
        if (rd_q.size() == 0) begin
          chk("rd_unexpected", {15'd0, read_ready}, 16'd0);
        end else begin
          x = rd_q.pop_front();
          chk_int("rd_cycle", cyc, x.due);
          chk("rd_data", rdata, x.data);
          held = x.data;
        end
      end else begin
        chk("rdata_hold", rdata, held);
      end
      if (write_done) begin
        if (wd_q.size() == 0) begin
          chk("wd_unexpected", {15'd0, write_done}, 16'd0);
        end else begin
          wdue = wd_q.pop_front();
          chk_int("wd_cycle", cyc, wdue);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    logic [15:0] ra;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("init_busy", {15'd0, busy}, 16'd0);
    chk("init_read_ready", {15'd0, read_ready}, 16'd0);
    chk("init_write_done", {15'd0, write_done}, 16'd0);
    chk("init_rdata", rdata, 16'h0000);
    idle_from = cyc + 1;
    held      = '0;
    mon_en    = 1'b1;

    for (int i = 0; i < DEPTH; i++) issue(1'b0, 1'b1, 16'(i), 16'($urandom));

    // Write then read back.
    issue(1'b0, 1'b1, 16'h0005, 16'hBEEF);
    issue(1'b1, 1'b0, 16'h0005, 16'h0000);
    idle_cycles(LAT + 2);
    // Read while busy is ignored.
    issue(1'b1, 1'b0, 16'h0020, 16'h0000);
    issue(1'b1, 1'b0, 16'h0007, 16'h0000);
    idle_cycles(LAT + 2);
    // Write while busy is ignored.
    issue(1'b1, 1'b0, 16'h0030, 16'h0000);
    issue(1'b0, 1'b1, 16'h0030, 16'hDEAD);
    idle_cycles(LAT + 2);
    issue(1'b1, 1'b0, 16'h0030, 16'h0000);
    idle_cycles(LAT + 2);
    // Simultaneous read and write to the same address.
    issue(1'b1, 1'b1, 16'h0010, 16'h1234);
    idle_cycles(LAT + 2);
    // Address aliasing above ADDR_W.
    issue(1'b0, 1'b1, 16'h0103, 16'hA5A5);
    issue(1'b1, 1'b0, 16'h0003, 16'h0000);
    idle_cycles(LAT + 2);
    // Reset while a read is pending; memory survives.
    issue(1'b1, 1'b0, 16'h0005, 16'h0000);
    do_reset();
    idle_cycles(LAT + 3);
    issue(1'b1, 1'b0, 16'h0005, 16'h0000);
    idle_cycles(LAT + 2);
    // Back-to-back reads.
    issue(1'b1, 1'b0, 16'h0103, 16'h0000);
    idle_cycles(LAT + 1);
    issue(1'b1, 1'b0, 16'h0010, 16'h0000);
    idle_cycles(LAT + 2);

    for (int n = 0; n < 500; n++) begin
      r  = $urandom_range(0, 7);
      ra = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 15));
      case (r)
        0, 1, 2: issue(1'b1, 1'b0, ra, 16'($urandom));
        3, 4:    issue(1'b0, 1'b1, ra, 16'($urandom));
        5:       issue(1'b1, 1'b1, ra, 16'($urandom));
        default: idle_cycles(1);
      endcase
    end

    idle_cycles(LAT + 4);
    chk_int("rd_queue_drained", rd_q.size(), 0);
    chk_int("wd_queue_drained", wd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
